// File: rtl/datapath.sv
// Signed 16 x 16-bit register file with ADD/SUB/LOAD, a combinational overflow flag and a registered reg[0]>>>2 average.
// Optional build macro DATAPATH_SAT_EN: overflowing ADD/SUB results clamp to 0x7FFF/0x8000 instead of wrapping.
module datapath (
    input  logic        clk,
    input  logic        nReset,
    input  logic [1:0]  op,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [3:0]  dest,
    input  logic [15:0] ext_data,
    output logic        V,
    output logic [15:0] avg_out
);
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    logic [15:0] r_regs [16];
    logic [15:0] r_avg;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_ovf;
    logic        w_wr_en;
    logic [15:0] w_wr_data;
    logic [15:0] w_arith;
    op_t         w_op;

    assign w_op = op_t'(op);
    assign w_a  = r_regs[src1];
    assign w_b  = r_regs[src2];

    assign w_sum  = {w_a[15], w_a} + {w_b[15], w_b};
    assign w_diff = {w_a[15], w_a} - {w_b[15], w_b};

    // Overflow only when the operand signs allow it and the result sign disagrees with src1.
    assign w_add_ovf = (w_a[15] == w_b[15]) && (w_sum[15]  != w_a[15]);
    assign w_sub_ovf = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);

    always_comb begin
        w_wr_en   = 1'b0;
        w_ovf     = 1'b0;
        w_arith   = w_sum[15:0];
        w_wr_data = ext_data;
        unique case (w_op)
            OP_NOP: begin
                w_wr_en = 1'b0;
            end
            OP_LOAD: begin
                w_wr_en   = 1'b1;
                w_wr_data = ext_data;
            end
            OP_ADD: begin
                w_wr_en = 1'b1;
                w_ovf   = w_add_ovf;
                w_arith = w_sum[15:0];
            end
            OP_SUB: begin
                w_wr_en = 1'b1;
                w_ovf   = w_sub_ovf;
                w_arith = w_diff[15:0];
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
        if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
`ifdef DATAPATH_SAT_EN
            // For both ADD and SUB, overflow direction follows the sign of src1.
            if (w_ovf) begin
                w_wr_data = w_a[15] ? 16'h8000 : 16'h7FFF;
            end else begin
                w_wr_data = w_arith;
            end
`else
            w_wr_data = w_arith;
`endif
        end
    end

    assign V = w_ovf;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (w_wr_en) begin
            r_regs[dest] <= w_wr_data;
        end
    end

    // Updated from the write data itself so it moves on the same edge as reg[0].
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_avg <= 16'h0000;
        end else if (w_wr_en && (dest == 4'd0)) begin
            r_avg <= {{2{w_wr_data[15]}}, w_wr_data[15:2]};
        end
    end

    assign avg_out = r_avg;

endmodule

// File: tb/tb_datapath.sv
// Randomized self-checking bench for datapath against an integer-arithmetic reference model.
// Honours DATAPATH_SAT_EN the same way as the design build.
module tb_datapath;
    logic        clk;
    logic        nReset;
    logic [1:0]  op;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [15:0] ext_data;
    logic        V;
    logic [15:0] avg_out;

    int n_checks;
    int n_fail;

    int m_regs [16];
    int m_avg;
    logic last_v;

    datapath dut (
        .clk      (clk),
        .nReset   (nReset),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .ext_data (ext_data),
        .V        (V),
        .avg_out  (avg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int to_signed16(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic int floor_div4(input int t);
        return (t >= 0) ? t / 4 : -((-t + 3) / 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_avg = 0;
    endtask

    // One command: drive at negedge, check V mid-cycle, commit on posedge, check avg_out after.
    task automatic run_cmd(input logic [1:0] o, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] d, input logic [15:0] data);
        int a, b, r;
        bit ovf, wr;
        logic [31:0] rv;
        logic [15:0] wv;
        @(negedge clk);
        op = o; src1 = s1; src2 = s2; dest = d; ext_data = data;
        #1;
        a = m_regs[s1];
        b = m_regs[s2];
        ovf = 1'b0;
        wr = 1'b0;
        wv = 16'h0000;
        r = 0;
        if (o == 2'b01) begin
            wr = 1'b1;
            wv = data;
        end else if (o != 2'b00) begin
            r = (o == 2'b10) ? a + b : a - b;
            ovf = (r > 32767) || (r < -32768);
            wr = 1'b1;
`ifdef DATAPATH_SAT_EN
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
`endif
            rv = r;
            wv = rv[15:0];
        end
        last_v = V;
        chk("V", {31'd0, V}, {31'd0, ovf});
        @(posedge clk);
        if (wr) begin
            m_regs[d] = to_signed16(wv);
            if (d == 4'd0) m_avg = floor_div4(to_signed16(wv));
        end
        #1;
        rv = m_avg;
        chk("avg_out", {16'd0, avg_out}, {16'd0, rv[15:0]});
        $display("op=%0d src1=%0d src2=%0d dest=%0d data=%h V=%0b avg_out=%h", o, s1, s2, d, data, last_v, avg_out);
    endtask

    initial begin
        logic [15:0] pool [8];
        logic [15:0] d16;
        n_checks = 0;
        n_fail = 0;
        pool[0] = 16'h7FFF; pool[1] = 16'h8000; pool[2] = 16'h0001; pool[3] = 16'hFFFF;
        pool[4] = 16'h0000; pool[5] = 16'h4000; pool[6] = 16'hC000; pool[7] = 16'h7FFE;
        model_reset();
        nReset = 1'b0;
        op = 2'b10; src1 = 4'd1; src2 = 4'd2; dest = 4'd0; ext_data = 16'h0000;
        #1;
        chk("reset_avg", {16'd0, avg_out}, 32'h0);
        chk("reset_V", {31'd0, V}, 32'h0);
        @(negedge clk);
        op = 2'b00;
        nReset = 1'b1;

        // LOAD/ADD basics
        run_cmd(2'b01, 4'd0, 4'd0, 4'd1, 16'h0010);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd2, 16'h0020);
        run_cmd(2'b10, 4'd1, 4'd2, 4'd0, 16'h0000);
        chk("add_V", {31'd0, last_v}, 32'h0);
        chk("add_avg", {16'd0, avg_out}, 32'h000C);

        // ADD overflow
        run_cmd(2'b01, 4'd0, 4'd0, 4'd1, 16'h7FFF);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd2, 16'h0001);
        run_cmd(2'b10, 4'd1, 4'd2, 4'd0, 16'h0000);
        chk("add_ovf_V", {31'd0, last_v}, 32'h1);
`ifdef DATAPATH_SAT_EN
        chk("add_ovf_avg", {16'd0, avg_out}, 32'h1FFF);
`else
        chk("add_ovf_avg", {16'd0, avg_out}, 32'h0000E000);
`endif

        // SUB overflow and plain SUB
        run_cmd(2'b01, 4'd0, 4'd0, 4'd1, 16'h8000);
        run_cmd(2'b11, 4'd1, 4'd2, 4'd0, 16'h0000);
        chk("sub_ovf_V", {31'd0, last_v}, 32'h1);
`ifdef DATAPATH_SAT_EN
        chk("sub_ovf_avg", {16'd0, avg_out}, 32'h0000E000);
`else
        chk("sub_ovf_avg", {16'd0, avg_out}, 32'h1FFF);
`endif
        run_cmd(2'b01, 4'd0, 4'd0, 4'd1, 16'h0005);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd2, 16'h0003);
        run_cmd(2'b11, 4'd1, 4'd2, 4'd0, 16'h0000);
        chk("sub_V", {31'd0, last_v}, 32'h0);
        run_cmd(2'b10, 4'd0, 4'd0, 4'd0, 16'h0000);
        chk("sub_double_avg", {16'd0, avg_out}, 32'h0001);

        // Negative averages
        run_cmd(2'b01, 4'd0, 4'd0, 4'd0, 16'hFFF8);
        chk("neg_avg_m8", {16'd0, avg_out}, 32'h0000FFFE);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd0, 16'hFFFF);
        chk("neg_avg_m1", {16'd0, avg_out}, 32'h0000FFFF);

        // Collision: operands use pre-edge value
        run_cmd(2'b01, 4'd0, 4'd0, 4'd3, 16'h0004);
        run_cmd(2'b10, 4'd3, 4'd3, 4'd3, 16'h0000);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd4, 16'h0000);
        run_cmd(2'b10, 4'd3, 4'd4, 4'd0, 16'h0000);
        chk("collision_avg", {16'd0, avg_out}, 32'h0002);

        // NOP holds everything
        for (int i = 0; i < 5; i++) begin
            run_cmd(2'b00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd0, 16'($urandom));
            chk("nop_avg", {16'd0, avg_out}, 32'h0002);
        end

        // Randomized traffic, biased toward overflow-prone values
        for (int i = 0; i < 400; i++) begin
            d16 = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            run_cmd(2'($urandom), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), d16);
        end

        // Asynchronous reset mid-operation
        run_cmd(2'b01, 4'd0, 4'd0, 4'd5, 16'h7FFF);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd6, 16'h7FFF);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd0, 16'h1234);
        @(negedge clk);
        op = 2'b10; src1 = 4'd5; src2 = 4'd6; dest = 4'd0;
        #1;
        chk("pre_reset_V", {31'd0, V}, 32'h1);
        chk("pre_reset_avg", {16'd0, avg_out}, 32'h048D);
        #1;
        nReset = 1'b0;
        #1;
        chk("async_reset_V", {31'd0, V}, 32'h0);
        chk("async_reset_avg", {16'd0, avg_out}, 32'h0);
        @(posedge clk);
        #1;
        chk("held_reset_avg", {16'd0, avg_out}, 32'h0);
        @(negedge clk);
        op = 2'b00;
        nReset = 1'b1;
        model_reset();
        run_cmd(2'b10, 4'd5, 4'd6, 4'd0, 16'h0000);
        chk("post_reset_V", {31'd0, last_v}, 32'h0);
        run_cmd(2'b01, 4'd0, 4'd0, 4'd7, 16'h0040);
        run_cmd(2'b10, 4'd7, 4'd5, 4'd0, 16'h0000);
        chk("post_reset_avg", {16'd0, avg_out}, 32'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
